// File: rtl/mem_ctrl_pkg.sv
// Shared constants and types for the memory controller: bus widths, mem_len
// codes, IO address select and controller states.
package mem_ctrl_pkg;
  localparam int AddrLen = 32;
  localparam int InstLen = 32;
  localparam logic [InstLen-1:0] ZERO_WORD = '0;

  localparam logic [1:0] MEM_LEN_B = 2'b00;
  localparam logic [1:0] MEM_LEN_H = 2'b01;
  localparam logic [1:0] MEM_LEN_W = 2'b10;

  // addr[17:16] == 2'b11 selects the IO space (UART)
  localparam int         IO_SEL_HI = 17;
  localparam int         IO_SEL_LO = 16;
  localparam logic [1:0] IO_SEL    = 2'b11;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  function automatic logic [2:0] len_bytes(input logic [1:0] len);
    case (len)
      MEM_LEN_B: len_bytes = 3'd1;
      MEM_LEN_H: len_bytes = 3'd2;
      default:   len_bytes = 3'd4;
    endcase
  endfunction
endpackage

// File: rtl/mem_ctrl_if.sv
// Request/response and RAM-bus signals of the memory controller.
// slave = controller side, master = fetch/mem stage + RAM/IO side.
interface mem_ctrl_if;
  import mem_ctrl_pkg::*;

  logic               rdy;
  logic               jump_or_not;
  logic               if_request;
  logic [AddrLen-1:0] if_addr;
  logic [InstLen-1:0] if_inst_o;
  logic               if_enable;
  logic               mem_request;
  logic               mem_we;
  logic [AddrLen-1:0] mem_addr;
  logic [1:0]         mem_len;
  logic [31:0]        mem_wdata;
  logic [31:0]        mem_rdata;
  logic               mem_enable;
  logic [7:0]         ram_din;
  logic [7:0]         ram_dout;
  logic [AddrLen-1:0] ram_a;
  logic               ram_wr;
  logic               io_buffer_full;

  modport slave (
    input  rdy, jump_or_not, if_request, if_addr, mem_request, mem_we,
           mem_addr, mem_len, mem_wdata, ram_din, io_buffer_full,
    output if_inst_o, if_enable, mem_rdata, mem_enable, ram_dout, ram_a, ram_wr
  );

  modport master (
    output rdy, jump_or_not, if_request, if_addr, mem_request, mem_we,
           mem_addr, mem_len, mem_wdata, ram_din, io_buffer_full,
    input  if_inst_o, if_enable, mem_rdata, mem_enable, ram_dout, ram_a, ram_wr
  );
endinterface

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: sequences 1/2/4 byte RAM accesses for fetch and
// memory stage. Define UART_FULL_CHECK_EN to stall IO writes while the UART FIFO is full.
module mem_ctrl
  import mem_ctrl_pkg::*;
(
  input logic       clk,
  input logic       rst,
  mem_ctrl_if.slave bus
);
  state_e             state, state_nx;
  logic               is_mem, we;
  logic [AddrLen-1:0] addr, cur_a;
  logic [3:0][7:0]    wbytes, lanes;
  logic [2:0]         n, cnt;
  logic               cap_vld;
  logic [1:0]         cap_idx;
  logic               accept, issuing, stall, fire, cancel;

  always_comb begin
    cur_a   = addr + AddrLen'(cnt);
    issuing = (state == BUSY) && (cnt < n);
`ifdef UART_FULL_CHECK_EN
    stall   = we && (cur_a[IO_SEL_HI:IO_SEL_LO] == IO_SEL) && bus.io_buffer_full;
`else
    stall   = 1'b0;
`endif
    fire    = issuing && bus.rdy && !stall;
    cancel  = !is_mem && bus.jump_or_not;
    accept  = (state == IDLE) && bus.rdy &&
              (bus.mem_request || (bus.if_request && !bus.jump_or_not));
  end

  always_comb begin
    state_nx       = state;
    bus.ram_a      = '0;
    bus.ram_dout   = '0;
    bus.ram_wr     = 1'b0;
    bus.if_enable  = 1'b0;
    bus.if_inst_o  = ZERO_WORD;
    bus.mem_enable = 1'b0;
    bus.mem_rdata  = '0;
    case (state)
      IDLE: if (accept) state_nx = BUSY;
      BUSY: begin
        if (cancel)                                state_nx = IDLE;
        else if (fire && we && cnt == n - 3'd1)    state_nx = DONE;
        // loads finish once every byte is issued and the last one is landing
        else if (!we && cnt == n && bus.rdy)       state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (issuing) begin
      bus.ram_a = cur_a;
      if (we) bus.ram_dout = wbytes[cnt[1:0]];
    end
    bus.ram_wr = fire && we;
    if (state == DONE) begin
      if (is_mem) begin
        bus.mem_enable = 1'b1;
        bus.mem_rdata  = lanes;
      end else if (!bus.jump_or_not) begin
        bus.if_enable  = 1'b1;
        bus.if_inst_o  = lanes;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      is_mem  <= 1'b0;
      we      <= 1'b0;
      addr    <= '0;
      wbytes  <= '0;
      n       <= '0;
      cnt     <= '0;
      cap_vld <= 1'b0;
      cap_idx <= '0;
      lanes   <= '0;
    end else begin
      state   <= state_nx;
      cap_vld <= fire && !we;
      if (fire) begin
        cnt     <= cnt + 3'd1;
        cap_idx <= cnt[1:0];
      end
      if (cap_vld) lanes[cap_idx] <= bus.ram_din;
      // accept last so a stale capture from a cancelled fetch cannot leak in
      if (accept) begin
        is_mem <= bus.mem_request;
        we     <= bus.mem_request && bus.mem_we;
        addr   <= bus.mem_request ? bus.mem_addr : bus.if_addr;
        wbytes <= bus.mem_wdata;
        n      <= bus.mem_request ? len_bytes(bus.mem_len) : 3'd4;
        cnt    <= '0;
        lanes  <= '0;
      end
    end
  end
endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: completions are checked against a queue of
// expected (port, data, cycle) entries; RAM bus activity is checked inline.
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  typedef struct {
    logic        is_mem;
    logic [31:0] data;
    int          at;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   t0;
  int   wr_at;
  exp_t exp_q[$];
  exp_t mon_e;
  logic [7:0] ram [0:65535];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_ctrl_if bus();
  mem_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  // RAM answers one cycle after the address
  always @(posedge clk) bus.ram_din <= ram[bus.ram_a[15:0]];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    #3;
  endtask

  task automatic push(input logic is_mem, input logic [31:0] d, input int at);
    exp_t e;
    e.is_mem = is_mem;
    e.data   = d;
    e.at     = at;
    exp_q.push_back(e);
  endtask

  // wait for one completion, drop the matching request, land in the next cycle
  task automatic wait_en();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (bus.mem_enable) begin bus.mem_request = 1'b0; seen = 1'b1; end
      if (bus.if_enable)  begin bus.if_request  = 1'b0; seen = 1'b1; end
    end
    if (!seen) chk("timeout", 32'd0, 32'd1);
    tick();
  endtask

  always @(negedge clk) begin
    if (!rst && (bus.if_enable || bus.mem_enable)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_en", {30'b0, bus.mem_enable, bus.if_enable}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("en_both", {31'b0, bus.if_enable & bus.mem_enable}, 32'd0);
        chk("en_port", {31'b0, bus.mem_enable}, {31'b0, mon_e.is_mem});
        chk("en_data", mon_e.is_mem ? bus.mem_rdata : bus.if_inst_o, mon_e.data);
        chk("en_cycle", cyc, mon_e.at);
      end
    end
  end

  initial begin
    bus.rdy = 1'b1; bus.jump_or_not = 1'b0; bus.if_request = 1'b0; bus.if_addr = '0;
    bus.mem_request = 1'b0; bus.mem_we = 1'b0; bus.mem_addr = '0; bus.mem_len = 2'b00;
    bus.mem_wdata = '0; bus.io_buffer_full = 1'b0;
    for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
    ram[16'h1000] = 8'h13; ram[16'h1001] = 8'h05; ram[16'h1002] = 8'h00; ram[16'h1003] = 8'h00;
    ram[16'h1004] = 8'h93; ram[16'h1005] = 8'h00; ram[16'h1006] = 8'h10; ram[16'h1007] = 8'h00;
    ram[16'h0000] = 8'h37; ram[16'h0001] = 8'h12;
    ram[16'h2000] = 8'hFF;
    ram[16'hFFFE] = 8'hAA; ram[16'hFFFF] = 8'hBB;

    // reset state
    tick(); mid();
    chk("rst_ram_a", bus.ram_a, 32'd0);
    chk("rst_ram_wr", {31'b0, bus.ram_wr}, 32'd0);
    chk("rst_ram_dout", {24'b0, bus.ram_dout}, 32'd0);
    chk("rst_if_en", {31'b0, bus.if_enable}, 32'd0);
    chk("rst_mem_en", {31'b0, bus.mem_enable}, 32'd0);
    chk("rst_inst", bus.if_inst_o, 32'd0);
    chk("rst_rdata", bus.mem_rdata, 32'd0);
    tick(); rst = 1'b0; tick();

    // plain fetch
    t0 = cyc;
    bus.if_request = 1'b1; bus.if_addr = 32'h1000;
    push(1'b0, 32'h0000_0513, t0 + 6);
    for (int k = 0; k < 4; k++) begin
      tick(); mid();
      chk("fetch_a", bus.ram_a, 32'h1000 + k);
      chk("fetch_wr", {31'b0, bus.ram_wr}, 32'd0);
    end
    wait_en();

    // memory stage beats a simultaneous fetch
    t0 = cyc;
    bus.if_request = 1'b1; bus.if_addr = 32'h0;
    bus.mem_request = 1'b1; bus.mem_we = 1'b0; bus.mem_addr = 32'h2000; bus.mem_len = MEM_LEN_B;
    push(1'b1, 32'h0000_00FF, t0 + 3);
    push(1'b0, 32'h0000_1237, t0 + 10);
    wait_en();
    wait_en();

    // half store
    t0 = cyc;
    bus.mem_request = 1'b1; bus.mem_we = 1'b1; bus.mem_addr = 32'h10;
    bus.mem_len = MEM_LEN_H; bus.mem_wdata = 32'h1234_BEEF;
    push(1'b1, 32'd0, t0 + 3);
    tick(); mid();
    chk("sh_wr0", {31'b0, bus.ram_wr}, 32'd1);
    chk("sh_a0", bus.ram_a, 32'h10);
    chk("sh_d0", {24'b0, bus.ram_dout}, 32'hEF);
    tick(); mid();
    chk("sh_wr1", {31'b0, bus.ram_wr}, 32'd1);
    chk("sh_a1", bus.ram_a, 32'h11);
    chk("sh_d1", {24'b0, bus.ram_dout}, 32'hBE);
    wait_en();
    bus.mem_we = 1'b0;

    // fetch cancelled by a jump, new fetch taken as soon as IDLE
    bus.if_request = 1'b1; bus.if_addr = 32'h1000;
    tick(); tick(); tick();
    bus.jump_or_not = 1'b1; bus.if_request = 1'b0;
    mid();
    chk("cancel_en", {31'b0, bus.if_enable}, 32'd0);
    tick();
    bus.jump_or_not = 1'b0;
    mid();
    chk("cancel_idle_a", bus.ram_a, 32'd0);
    t0 = cyc;
    bus.if_request = 1'b1; bus.if_addr = 32'h1004;
    push(1'b0, 32'h0010_0093, t0 + 6);
    wait_en();

    // fetch not accepted while jump_or_not is high in IDLE
    bus.if_request = 1'b1; bus.if_addr = 32'h1000; bus.jump_or_not = 1'b1;
    tick(); mid();
    chk("jump_idle_a", bus.ram_a, 32'd0);
    bus.jump_or_not = 1'b0;
    t0 = cyc;
    push(1'b0, 32'h0000_0513, t0 + 6);
    wait_en();

    // word load (len code 11) with rdy low for two cycles
    t0 = cyc;
    bus.mem_request = 1'b1; bus.mem_we = 1'b0; bus.mem_addr = 32'h1000; bus.mem_len = 2'b11;
    push(1'b1, 32'h0000_0513, t0 + 8);
    tick(); tick();
    bus.rdy = 1'b0;
    tick(); tick();
    bus.rdy = 1'b1;
    mid();
    chk("rdy_reissue_a", bus.ram_a, 32'h1001);
    wait_en();

    // address wrap across 0xFFFFFFFF
    t0 = cyc;
    bus.if_request = 1'b1; bus.if_addr = 32'hFFFF_FFFE;
    push(1'b0, 32'h1237_BBAA, t0 + 6);
    tick(); tick(); tick(); mid();
    chk("wrap_a", bus.ram_a, 32'd0);
    wait_en();

    // byte store to IO with the UART FIFO full for three cycles
`ifdef UART_FULL_CHECK_EN
    wr_at = 4;
`else
    wr_at = 1;
`endif
    t0 = cyc;
    bus.mem_request = 1'b1; bus.mem_we = 1'b1; bus.mem_addr = 32'h0003_0000;
    bus.mem_len = MEM_LEN_B; bus.mem_wdata = 32'h41;
    bus.io_buffer_full = 1'b1;
    push(1'b1, 32'd0, t0 + wr_at + 1);
    for (int k = 1; k <= wr_at; k++) begin
      tick();
      if (k == 4) bus.io_buffer_full = 1'b0;
      mid();
      chk("io_wr", {31'b0, bus.ram_wr}, {31'b0, k == wr_at});
      if (k == wr_at) begin
        chk("io_a", bus.ram_a, 32'h0003_0000);
        chk("io_d", {24'b0, bus.ram_dout}, 32'h41);
      end
    end
    bus.io_buffer_full = 1'b0;
    wait_en();
    bus.mem_we = 1'b0;

    // reset in the middle of a fetch
    bus.if_request = 1'b1; bus.if_addr = 32'h1000;
    tick(); tick();
    rst = 1'b1; bus.if_request = 1'b0;
    tick(); mid();
    chk("midrst_a", bus.ram_a, 32'd0);
    chk("midrst_wr", {31'b0, bus.ram_wr}, 32'd0);
    chk("midrst_en", {31'b0, bus.if_enable}, 32'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    t0 = cyc;
    bus.if_request = 1'b1; bus.if_addr = 32'h1004;
    push(1'b0, 32'h0010_0093, t0 + 6);
    wait_en();

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
